mips_pipeline_fetch_stage: RTL and testbench
============================================

MIPS_PIPELINE_FETCH_STAGE -- requirements
Module: Mips_Pipeline_Fetch_stage

Interface
REQ-001 SHALL have parameter ADDR_L, default 64, meaning the instruction ROM depth in words.
REQ-002 SHALL have parameter ADDR_W, default Util_Math_log2(ADDR_L), meaning the ROM word-address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetched instruction.
REQ-004 ctrl.clock  input  1  sole clock, rising edge, carried in the Data_Control_Control_T bundle `ctrl`.
REQ-005 ctrl.reset  input  1  reset, asynchronous, active-high, carried in `ctrl`.
REQ-006 stall  input  1  hazard hold: PC held and current ID output re-presented.
REQ-007 flush  input  1  kills the instruction currently presented to decode.
REQ-008 redirect  input  1  taken branch, jump or jr: fetch from redirectAddr next.
REQ-009 redirectAddr  input  32  byte target address.
REQ-010 romAddr  output  ADDR_W  word address to the synchronous-read ROM, equal to pcNext[ADDR_W+1:2].
REQ-011 romOut  input  32  ROM data for the address presented on the previous edge.
REQ-012 idInstruction  output  32  instruction to decode, equal to romOut.
REQ-013 idPc  output  32  byte address of idInstruction.
REQ-014 idPcPlus4  output  32  idPc+4, used for link and branch base.
REQ-015 idValid  output  1  idInstruction is a real, on-path instruction.
REQ-016 fault  output  1  sticky fetch fault.
REQ-017 fetchCount  output  32  count of instructions accepted by decode.

Function
REQ-018 SHALL implement FSM states PRIME, RUN and FAULT.
REQ-019 PRIME SHALL last exactly one cycle after reset deassertion, drive pcNext=RESET_PC and idValid=0, then go to RUN.
REQ-020 In RUN, pcNext SHALL be selected with priority redirect > stall > sequential: redirectAddr, else pc, else pc+4.
REQ-021 pc SHALL load pcNext every edge, so romOut in cycle t+1 is the word at pc.
REQ-022 PC arithmetic SHALL be 32-bit modulo 2^32 and SHALL never be truncated to ADDR_W.
REQ-023 idValid SHALL equal validReg & ~flush & ~redirect, where validReg is 1 in RUN and 0 otherwise.
REQ-024 A redirect SHALL therefore kill the wrong-path instruction in the same cycle.
REQ-025 Stall together with flush SHALL produce a bubble while holding the PC.
REQ-026 Redirect together with stall SHALL let redirect win, and the target SHALL appear next cycle.
REQ-027 While stalled, romAddr SHALL re-present pc so idInstruction, idPc and idPcPlus4 stay stable.
REQ-028 In RUN, the FSM SHALL go to FAULT when pcNext[1:0]!=0 or pcNext>=4*ADDR_L.
REQ-029 FAULT SHALL be sticky until reset, with fault=1, idValid=0, pc frozen and romAddr frozen.
REQ-030 The faulting address SHALL be retained on idPc.
REQ-031 fetchCount SHALL increment when idValid & ~stall, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-032 Latency SHALL be one cycle from a pcNext decision to the corresponding idInstruction.

Reset
REQ-033 On ctrl.reset=1, asynchronously: state=PRIME, pc=RESET_PC, validReg=0, fault=0, fetchCount=0.
REQ-034 During reset the outputs SHALL be: idValid=0, idPc=RESET_PC, idPcPlus4=RESET_PC+4, romAddr=RESET_PC[ADDR_W+1:2].
REQ-035 Reset asserted mid-run or in FAULT SHALL abandon all state, and no instruction SHALL be reported valid until PRIME completes.

Structure
REQ-036 State encoding SHALL be defined in a shared Mips/Pipeline package with T/W macros in the Mips_Type_* style.
REQ-037 An IF/ID field-extraction macro bundle for idInstruction/idPc/idPcPlus4/idValid SHALL also be defined in the shared package.
REQ-038 Word width SHALL reuse Mips_Type_Word.
REQ-039 The design SHALL contain one sub-module, Mips_Pipeline_Fetch_nextPc, a combinational next-PC mux and range/alignment checker.

Verification
REQ-040 Reset release with ADDR_L=64 -> cycle 1: romAddr=0 and idValid=0; cycle 2: idPc=0 and idValid=1; then idPc=4,8,12 on consecutive cycles.
REQ-041 stall high for 3 cycles at idPc=0x10 -> idPc=0x10 and the instruction stay stable, fetchCount frozen; resume gives 0x14.
REQ-042 redirect=1 with redirectAddr=0x40 at idPc=0x08 -> idValid=0 that cycle; next cycle idPc=0x40 and idValid=1; redirect together with stall gives the same result.
REQ-043 redirectAddr=0x42, or sequential fetch reaching 0x100 with ADDR_L=64 -> fault=1 next cycle, idValid=0 forever, and idPc holds 0x42 or 0x100.
REQ-044 Reset asserted asynchronously mid-cycle while in FAULT -> immediate fault=0, idPc=RESET_PC, fetchCount=0; PRIME then RUN sequence repeats.
REQ-045 Forced fetchCount=32'hFFFF_FFFF plus one accepted instruction -> fetchCount=0; flush with stall -> idValid=0 and PC held.

Source files
------------

// File: rtl/mips_pipeline_fetch_stage_pkg.sv
// Shared MIPS pipeline types for the fetch stage.
//   MIPS_TYPE_WORD_*              : machine word width/type
//   MIPS_PIPELINE_FETCH_STATE_*   : fetch FSM state width/type
//   MIPS_PIPELINE_IFID_*          : IF/ID bundle field extraction
//   data_control_control_t        : clock/reset control bundle
//   if_id_t                       : IF/ID pipeline payload
//   util_math_log2                : ceil(log2(n)) for address widths
`ifndef MIPS_PIPELINE_FETCH_STAGE_PKG_SV
`define MIPS_PIPELINE_FETCH_STAGE_PKG_SV

`define MIPS_TYPE_WORD_W 32
`define MIPS_TYPE_WORD_T logic [`MIPS_TYPE_WORD_W-1:0]

`define MIPS_PIPELINE_FETCH_STATE_W 2
`define MIPS_PIPELINE_FETCH_STATE_T logic [`MIPS_PIPELINE_FETCH_STATE_W-1:0]

`define MIPS_PIPELINE_IFID_INSTRUCTION(b) (b.instruction)
`define MIPS_PIPELINE_IFID_PC(b)          (b.pc)
`define MIPS_PIPELINE_IFID_PC_PLUS4(b)    (b.pc_plus4)
`define MIPS_PIPELINE_IFID_VALID(b)       (b.valid)

package mips_pipeline_fetch_stage_pkg;

   localparam int unsigned WORD_W = `MIPS_TYPE_WORD_W;

   typedef `MIPS_TYPE_WORD_T word_t;

   typedef enum `MIPS_PIPELINE_FETCH_STATE_T {
      ST_PRIME = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic clock;
      logic reset;
   } data_control_control_t;

   typedef struct packed {
      word_t instruction;
      word_t pc;
      word_t pc_plus4;
      logic  valid;
   } if_id_t;

   // Smallest r with 2**r >= n.
   function automatic int unsigned util_math_log2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/mips_pipeline_fetch_stage_next_pc.sv
// Combinational next-PC selection and fetch-address checker.
//   state         : current fetch FSM state
//   pc            : current fetch PC (byte address)
//   redirect      : taken branch/jump target valid
//   stall         : hold PC
//   redirect_addr : redirect byte target
//   pc_next_c     : selected next PC
//   bad_c         : next PC is misaligned or beyond the ROM (RUN only)
module mips_pipeline_fetch_stage_next_pc
   import mips_pipeline_fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_L   = 64,
   parameter word_t       RESET_PC = 32'h0000_0000
) (
   input  fetch_state_e state,
   input  logic [31:0]  pc,
   input  logic         redirect,
   input  logic         stall,
   input  logic [31:0]  redirect_addr,
   output logic [31:0]  pc_next_c,
   output logic         bad_c
);

   localparam word_t ROM_BYTES = word_t'(4 * ADDR_L);

   // Priority redirect > stall > sequential; full 32-bit arithmetic.
   always_comb begin
      pc_next_c = pc;
      bad_c     = 1'b0;
      unique case (state)
         ST_PRIME: pc_next_c = RESET_PC;
         ST_RUN: begin
            if (redirect)   pc_next_c = redirect_addr;
            else if (stall) pc_next_c = pc;
            else            pc_next_c = pc + 32'd4;
            bad_c = (pc_next_c[1:0] != 2'b00) || (pc_next_c >= ROM_BYTES);
         end
         default: pc_next_c = pc;
      endcase
   end

endmodule

// File: rtl/mips_pipeline_fetch_stage.sv
// MIPS pipeline instruction fetch stage with synchronous-read ROM interface.
//   ctrl           : clock (rising edge) and async active-high reset bundle
//   stall          : hold PC, re-present current IF/ID output
//   flush          : kill instruction presented to decode
//   redirect       : fetch from redirect_addr next
//   redirect_addr  : redirect byte target
//   rom_addr       : ROM word address (from next PC)
//   rom_out        : ROM data for address presented on previous edge
//   id_instruction : instruction to decode
//   id_pc          : byte address of id_instruction
//   id_pc_plus4    : id_pc + 4
//   id_valid       : id_instruction is on-path and real
//   fault          : sticky fetch fault
//   fetch_count    : instructions accepted by decode
module mips_pipeline_fetch_stage
   import mips_pipeline_fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_L   = 64,
   parameter int unsigned ADDR_W   = util_math_log2(ADDR_L),
   parameter word_t       RESET_PC = 32'h0000_0000
) (
   input  data_control_control_t ctrl,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect,
   input  logic [31:0]           redirect_addr,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [31:0]           rom_out,
   output logic [31:0]           id_instruction,
   output logic [31:0]           id_pc,
   output logic [31:0]           id_pc_plus4,
   output logic                  id_valid,
   output logic                  fault,
   output logic [31:0]           fetch_count
);

   logic         clk;
   logic         rst;
   fetch_state_e state;
   fetch_state_e state_next;
   logic         valid_reg;
   logic         valid_d;
   logic         fault_d;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic         bad;
   if_id_t       ifid;

   assign clk = ctrl.clock;
   assign rst = ctrl.reset;

   mips_pipeline_fetch_stage_next_pc #(
      .ADDR_L   (ADDR_L),
      .RESET_PC (RESET_PC)
   ) u_next_pc (
      .state         (state),
      .pc            (pc),
      .redirect      (redirect),
      .stall         (stall),
      .redirect_addr (redirect_addr),
      .pc_next_c     (pc_next),
      .bad_c         (bad)
   );

   // FSM state and registered FSM outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_PRIME;
         valid_reg <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_next;
         valid_reg <= valid_d;
         fault     <= fault_d;
      end
   end

   // Next state: one PRIME cycle, RUN until a bad fetch address, FAULT sticks.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_PRIME: state_next = ST_RUN;
         ST_RUN:   if (bad) state_next = ST_FAULT;
         ST_FAULT: state_next = ST_FAULT;
         default:  state_next = ST_PRIME;
      endcase
   end

   // FSM outputs, registered so they track the state they describe.
   always_comb begin
      valid_d = 1'b0;
      fault_d = 1'b0;
      valid_d = (state_next == ST_RUN);
      fault_d = (state_next == ST_FAULT);
   end

   // PC loads next PC every edge; in FAULT next PC is pc, so it freezes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= RESET_PC;
      else     pc <= pc_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   fetch_count <= 32'd0;
      else if (id_valid && !stall) fetch_count <= fetch_count + 32'd1;
   end

   assign rom_addr = pc_next[ADDR_W+1:2];

   // A redirect or flush kills the wrong-path instruction in the same cycle.
   assign ifid = '{instruction: rom_out,
                   pc:          pc,
                   pc_plus4:    pc + 32'd4,
                   valid:       valid_reg & ~flush & ~redirect};

   assign id_instruction = `MIPS_PIPELINE_IFID_INSTRUCTION(ifid);
   assign id_pc          = `MIPS_PIPELINE_IFID_PC(ifid);
   assign id_pc_plus4    = `MIPS_PIPELINE_IFID_PC_PLUS4(ifid);
   assign id_valid       = `MIPS_PIPELINE_IFID_VALID(ifid);

endmodule

// File: tb/tb_mips_pipeline_fetch_stage.sv
// Directed self-checking bench for mips_pipeline_fetch_stage (ADDR_L=64, RESET_PC=0).
module tb_mips_pipeline_fetch_stage;
   import mips_pipeline_fetch_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   data_control_control_t ctrl;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = 32'd0;
   logic [5:0]  rom_addr;
   logic [31:0] rom_out;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_valid;
   logic        fault;
   logic [31:0] fetch_count;
   logic [31:0] rom [0:63];
   int checks = 0;
   int errors = 0;

   assign ctrl = '{clock: clk, reset: rst};
   always #5 clk = ~clk;

   // Synchronous-read instruction ROM.
   always @(posedge clk) rom_out <= rom[rom_addr];

   mips_pipeline_fetch_stage dut (
      .ctrl           (ctrl),
      .stall          (stall),
      .flush          (flush),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .rom_addr       (rom_addr),
      .rom_out        (rom_out),
      .id_instruction (id_instruction),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4),
      .id_valid       (id_valid),
      .fault          (fault),
      .fetch_count    (fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit into the first RUN cycle (id_pc = 0).
   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", id_pc); end
      checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h expected 00000004", id_pc_plus4); end
      checks++; if (rom_addr !== 6'd0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00", rom_addr); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0 || rom_addr !== 6'd0) begin errors++; $display("FAIL prime_cycle: got valid=%b rom_addr=%h expected valid=0 rom_addr=00", id_valid, rom_addr); end
      step();
      checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL first_fetch: got pc=%h valid=%b expected pc=00000000 valid=1", id_pc, id_valid); end
      checks++; if (id_instruction !== 32'hC0DE_0000) begin errors++; $display("FAIL first_instr: got %h expected c0de0000", id_instruction); end
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (id_pc !== 32'(4 * i) || id_valid !== 1'b1) begin errors++; $display("FAIL seq_pc_%0d: got pc=%h valid=%b expected pc=%h valid=1", i, id_pc, id_valid, 32'(4 * i)); end
         checks++; if (id_instruction !== (32'hC0DE_0000 + 32'(i))) begin errors++; $display("FAIL seq_instr_%0d: got %h expected %h", i, id_instruction, 32'hC0DE_0000 + 32'(i)); end
      end
      checks++; if (id_pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq_pc4: got %h expected 00000010", id_pc_plus4); end
      checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d expected 3", fetch_count); end
   endtask

   task automatic test_stall();
      step();
      checks++; if (id_pc !== 32'h10) begin errors++; $display("FAIL stall_start_pc: got %h expected 00000010", id_pc); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (id_pc !== 32'h10 || id_instruction !== 32'hC0DE_0004 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d: got pc=%h instr=%h valid=%b expected pc=00000010 instr=c0de0004 valid=1", i, id_pc, id_instruction, id_valid); end
         checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stall_count_%0d: got %0d expected 4", i, fetch_count); end
         checks++; if (rom_addr !== 6'd4) begin errors++; $display("FAIL stall_rom_addr_%0d: got %h expected 04", i, rom_addr); end
         if (i < 2) step();
      end
      stall = 1'b0;
      step();
      checks++; if (id_pc !== 32'h14 || id_instruction !== 32'hC0DE_0005) begin errors++; $display("FAIL stall_resume: got pc=%h instr=%h expected pc=00000014 instr=c0de0005", id_pc, id_instruction); end
      checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL stall_resume_count: got %0d expected 5", fetch_count); end
   endtask

   task automatic test_redirect();
      for (int s = 0; s < 2; s++) begin
         do_reset();
         step(); step();
         checks++; if (id_pc !== 32'h08) begin errors++; $display("FAIL redir_pre_pc_%0d: got %h expected 00000008", s, id_pc); end
         redirect = 1'b1; redirect_addr = 32'h40; stall = (s == 1);
         #1;
         checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_kill_%0d: got %b expected 0", s, id_valid); end
         checks++; if (rom_addr !== 6'h10) begin errors++; $display("FAIL redir_rom_addr_%0d: got %h expected 10", s, rom_addr); end
         step();
         redirect = 1'b0; stall = 1'b0;
         #1;
         checks++; if (id_pc !== 32'h40 || id_valid !== 1'b1 || id_instruction !== 32'hC0DE_0010) begin errors++; $display("FAIL redir_target_%0d: got pc=%h valid=%b instr=%h expected pc=00000040 valid=1 instr=c0de0010", s, id_pc, id_valid, id_instruction); end
         checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL redir_count_%0d: got %0d expected 2", s, fetch_count); end
         step();
         checks++; if (id_pc !== 32'h44 || id_pc_plus4 !== 32'h48) begin errors++; $display("FAIL redir_next_%0d: got pc=%h pc4=%h expected pc=00000044 pc4=00000048", s, id_pc, id_pc_plus4); end
      end
   endtask

   task automatic test_fault_misaligned();
      do_reset();
      redirect = 1'b1; redirect_addr = 32'h42;
      step();
      redirect = 1'b0;
      #1;
      checks++; if (fault !== 1'b1 || id_valid !== 1'b0 || id_pc !== 32'h42) begin errors++; $display("FAIL misalign_fault: got fault=%b valid=%b pc=%h expected fault=1 valid=0 pc=00000042", fault, id_valid, id_pc); end
      step(); step();
      checks++; if (fault !== 1'b1 || id_valid !== 1'b0 || id_pc !== 32'h42 || rom_addr !== 6'h10) begin errors++; $display("FAIL misalign_sticky: got fault=%b valid=%b pc=%h rom_addr=%h expected fault=1 valid=0 pc=00000042 rom_addr=10", fault, id_valid, id_pc, rom_addr); end
   endtask

   task automatic test_fault_range();
      do_reset();
      for (int i = 0; i < 63; i++) step();
      checks++; if (id_pc !== 32'hFC || fault !== 1'b0 || id_valid !== 1'b1) begin errors++; $display("FAIL range_last: got pc=%h fault=%b valid=%b expected pc=000000fc fault=0 valid=1", id_pc, fault, id_valid); end
      step();
      checks++; if (fault !== 1'b1 || id_valid !== 1'b0 || id_pc !== 32'h100) begin errors++; $display("FAIL range_fault: got fault=%b valid=%b pc=%h expected fault=1 valid=0 pc=00000100", fault, id_valid, id_pc); end
      checks++; if (fetch_count !== 32'd64) begin errors++; $display("FAIL range_count: got %0d expected 64", fetch_count); end
      step(); step();
      checks++; if (fault !== 1'b1 || id_pc !== 32'h100 || fetch_count !== 32'd64) begin errors++; $display("FAIL range_sticky: got fault=%b pc=%h count=%0d expected fault=1 pc=00000100 count=64", fault, id_pc, fetch_count); end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (fault !== 1'b0 || id_pc !== 32'h0 || fetch_count !== 32'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got fault=%b pc=%h count=%0d valid=%b expected fault=0 pc=00000000 count=0 valid=0", fault, id_pc, fetch_count, id_valid); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL async_prime: got %b expected 0", id_valid); end
      step();
      checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL async_run: got pc=%h valid=%b expected pc=00000000 valid=1", id_pc, id_valid); end
      step();
      checks++; if (id_pc !== 32'h4 || id_valid !== 1'b1) begin errors++; $display("FAIL async_seq: got pc=%h valid=%b expected pc=00000004 valid=1", id_pc, id_valid); end
   endtask

   task automatic test_wrap_flush();
      do_reset();
      force dut.fetch_count = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count;
      #1;
      checks++; if (fetch_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", fetch_count); end
      step();
      checks++; if (fetch_count !== 32'd0 || id_pc !== 32'h4) begin errors++; $display("FAIL wrap_zero: got count=%h pc=%h expected count=00000000 pc=00000004", fetch_count, id_pc); end
      stall = 1'b1; flush = 1'b1;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b expected 0", id_valid); end
      step();
      checks++; if (id_pc !== 32'h4 || fetch_count !== 32'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_hold: got pc=%h count=%0d valid=%b expected pc=00000004 count=0 valid=0", id_pc, fetch_count, id_valid); end
      stall = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_only_valid: got %b expected 0", id_valid); end
      step();
      flush = 1'b0;
      #1;
      checks++; if (id_pc !== 32'h8 || id_valid !== 1'b1 || fetch_count !== 32'd0) begin errors++; $display("FAIL flush_resume: got pc=%h valid=%b count=%0d expected pc=00000008 valid=1 count=0", id_pc, id_valid, fetch_count); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
      test_reset();
      test_stall();
      test_redirect();
      test_fault_misaligned();
      test_fault_range();
      test_async_reset();
      test_wrap_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
